// File: rtl/reg_file_fifo_pkg.sv
// Shared sizing for the 4-entry, 9-bit register file and the blocks that use it
// as a FIFO.
package reg_file_fifo_pkg;

  localparam int RF_DATA_W = 9;
  localparam int RF_ADDR_W = 2;
  localparam int RF_DEPTH  = 4;

  typedef logic [RF_ADDR_W:0] count_t;

endpackage

// File: rtl/reg_file_fifo_ctrl.sv
// Ring-order FIFO controller driving an external 2-read/1-write register file.
// Supports popping one word (head) or a pair (head, head+1) per cycle.
module reg_file_fifo_ctrl
  import reg_file_fifo_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_ready,
  input  logic              out_pair_ready,
  output logic              out_valid,
  output logic              out_pair_valid,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [ADDR_W:0]   count,
  output logic              pop_err,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd0_addr,
  output logic [ADDR_W-1:0] rf_rd1_addr,
  input  logic [DATA_W-1:0] rf_rd0_data,
  input  logic [DATA_W-1:0] rf_rd1_data
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop_one;
  logic              pop_two;
  logic              bad_pop;
  logic [ADDR_W:0]   count_next;

  // Full is judged on the registered count: no write-through even with a pop.
  assign in_ready       = (count != FULL);
  assign push           = in_valid & in_ready;
  assign out_valid      = (count != '0);
  assign out_pair_valid = (count >= TWO);

  assign rf_wr_en    = push;
  assign rf_wr_addr  = wr_ptr;
  assign rf_wr_data  = in_data;
  assign rf_rd0_addr = rd_ptr;
  assign rf_rd1_addr = rd_ptr + ADDR_W'(1);
  assign out_data0   = rf_rd0_data;
  assign out_data1   = rf_rd1_data;

  // A legal pair pop takes priority over a single pop in the same cycle.
  assign pop_two = out_pair_ready & out_pair_valid;
  assign pop_one = ~pop_two & out_ready & out_valid;
  assign bad_pop = (out_pair_ready & ~out_pair_valid) | (out_ready & ~out_valid);

  always_comb begin
    count_next = count + {{ADDR_W{1'b0}}, push}
                       - {{(ADDR_W-1){1'b0}}, pop_two, pop_one};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_two)
        rd_ptr <= rd_ptr + ADDR_W'(2);
      else if (pop_one)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next;
      if (bad_pop)
        pop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_fifo_ctrl.sv
// Bench for reg_file_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_reg_file_fifo_ctrl;

  localparam int DW = 9;
  localparam int AW = 2;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_ready = 1'b0;
  logic          out_pair_ready = 1'b0;
  logic          out_valid;
  logic          out_pair_valid;
  logic [DW-1:0] out_data0;
  logic [DW-1:0] out_data1;
  logic [AW:0]   count;
  logic          pop_err;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rf_rd0_addr;
  logic [AW-1:0] rf_rd1_addr;
  logic [DW-1:0] rf_rd0_data;
  logic [DW-1:0] rf_rd1_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_pair_ready(out_pair_ready),
    .out_valid(out_valid), .out_pair_valid(out_pair_valid),
    .out_data0(out_data0), .out_data1(out_data1),
    .count(count), .pop_err(pop_err),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
    .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data)
  );

  // Register file stand-in: clocked write, combinational reads.
  logic [DW-1:0] mem [DP];
  initial for (int i = 0; i < DP; i++) mem[i] = '0;
  always @(posedge clk) if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd0_data = mem[rf_rd0_addr];
  assign rf_rd1_data = mem[rf_rd1_addr];

  // Reference model: contents as a queue, head slot index, sticky error.
  int q[$];
  int head = 0;
  bit m_err = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      head = 0;
      m_err = 0;
    end else if (flush) begin
      q.delete();
      head = 0;
      m_err = 0;
    end else begin
      int n;
      bit do_push, pair, one;
      n = q.size();
      do_push = in_valid && (n != DP);
      pair = out_pair_ready && (n >= 2);
      one = !pair && out_ready && (n >= 1);
      if ((out_pair_ready && n < 2) || (out_ready && n == 0)) m_err = 1;
      if (pair) begin
        void'(q.pop_front());
        void'(q.pop_front());
        head = (head + 2) % DP;
      end else if (one) begin
        void'(q.pop_front());
        head = (head + 1) % DP;
      end
      if (do_push) q.push_back(int'(in_data));
    end
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("m_count", int'(count), n);
    chk("m_in_ready", int'(in_ready), int'(n != DP));
    chk("m_out_valid", int'(out_valid), int'(n >= 1));
    chk("m_out_pair_valid", int'(out_pair_valid), int'(n >= 2));
    chk("m_pop_err", int'(pop_err), int'(m_err));
    chk("m_rf_wr_en", int'(rf_wr_en), int'(in_valid && n != DP));
    chk("m_rd0_addr", int'(rf_rd0_addr), head);
    chk("m_rd1_addr", int'(rf_rd1_addr), (head + 1) % DP);
    if (rf_wr_en) begin
      chk("m_wr_addr", int'(rf_wr_addr), (head + n) % DP);
      chk("m_wr_data", int'(rf_wr_data), int'(in_data));
    end
    if (n >= 1) chk("m_out_data0", int'(out_data0), q[0]);
    if (n >= 2) chk("m_out_data1", int'(out_data1), q[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    out_pair_ready = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_rf_wr_en", int'(rf_wr_en), 0);
    chk("rst_pop_err", int'(pop_err), 0);
    rst = 1'b1;
    tick();

    // Two pushes, then read both back.
    in_valid = 1'b1; in_data = 9'd92; #1;
    chk("push0_addr", int'(rf_wr_addr), 0);
    tick();
    in_data = 9'd65; #1;
    chk("push1_addr", int'(rf_wr_addr), 1);
    tick();
    idle(); #1;
    chk("two_count", int'(count), 2);
    chk("two_data0", int'(out_data0), 92);
    chk("two_data1", int'(out_data1), 65);
    chk("two_pair_valid", int'(out_pair_valid), 1);
    out_pair_ready = 1'b1;
    tick();
    idle(); #1;
    chk("drain_count", int'(count), 0);

    // Fill to full, then a push attempt while popping must not write.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = DW'(12 + 22 * i);
      tick();
    end
    idle(); #1;
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    in_valid = 1'b1; in_data = 9'd99; out_ready = 1'b1; #1;
    chk("full_no_write", int'(rf_wr_en), 0);
    tick();
    idle(); #1;
    chk("full_pop_count", int'(count), 3);
    chk("full_pop_head", int'(out_data0), 34);
    chk("wrap_rd0_addr", int'(rf_rd0_addr), 3);
    chk("wrap_rd1_addr", int'(rf_rd1_addr), 0);
    chk("wrap_data1", int'(out_data1), 56);

    // Five push+pop cycles crossing the wrap point.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(100 + i); out_ready = 1'b1;
      tick();
      chk("wrap_step_count", int'(count), 3);
    end
    idle(); #1;
    chk("wrap_head", int'(out_data0), 102);
    out_ready = 1'b1;
    tick();
    idle(); #1;
    chk("pre_pair_count", int'(count), 2);

    // Push with both pop requests: pair wins.
    in_valid = 1'b1; in_data = 9'd7; out_ready = 1'b1; out_pair_ready = 1'b1;
    tick();
    idle(); #1;
    chk("pair_win_count", int'(count), 1);
    chk("pair_win_head", int'(out_data0), 7);

    // Illegal pair pop with one word stored.
    out_pair_ready = 1'b1;
    tick();
    idle(); #1;
    chk("bad_pop_err", int'(pop_err), 1);
    chk("bad_pop_count", int'(count), 1);
    tick();
    chk("bad_pop_sticky", int'(pop_err), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 9'd3;
    tick();
    idle(); #1;
    chk("flush_count", int'(count), 0);
    chk("flush_err", int'(pop_err), 0);

    // Asynchronous reset in the middle of a cycle.
    in_valid = 1'b1; in_data = 9'd41;
    tick();
    in_data = 9'd42;
    tick();
    chk("pre_rst_count", int'(count), 2);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    idle();
    tick();
    rst = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_fifo_ctrl.md
Name: reg_file_fifo_ctrl

Overview:
Master-side controller for the 4-entry, 9-bit, 2-read/1-write reg_file. It turns the register file into a 4-deep FIFO for the cipher datapath.
- Accepts plaintext/ciphertext words on a valid/ready input stream and issues reg_file writes in ring order.
- Drives both reg_file read ports so the consumer can pop one word (head) or a pair (head, head+1) per cycle.
- Sits between the byte/word source and the encrypt/decrypt core; reg_file is instantiated alongside it by the parent.

Parameters:
DATA_W, 9, word width; matches reg_file data width
ADDR_W, 2, reg_file address width
DEPTH, 4, entry count; must equal 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
flush  in  1  synchronous clear of pointers/count/error
in_valid  in  1  input word valid
in_data  in  DATA_W  input word
in_ready  out  1  controller can accept a word
out_ready  in  1  consumer pops one word (head)
out_pair_ready  in  1  consumer pops two words (head, head+1)
out_valid  out  1  at least 1 word stored
out_pair_valid  out  1  at least 2 words stored
out_data0  out  DATA_W  head word (= rd0_data)
out_data1  out  DATA_W  head+1 word (= rd1_data)
count  out  ADDR_W+1  occupancy, 0..DEPTH
pop_err  out  1  sticky: illegal pop requested
rf_wr_en  out  1  to reg_file wr_en
rf_wr_addr  out  ADDR_W  to reg_file wr_addr
rf_wr_data  out  DATA_W  to reg_file wr_data
rf_rd0_addr  out  ADDR_W  to reg_file rd0_addr
rf_rd1_addr  out  ADDR_W  to reg_file rd1_addr
rf_rd0_data  in  DATA_W  from reg_file rd0_data
rf_rd1_data  in  DATA_W  from reg_file rd1_data

Behaviour:
- reg_file contract: writes on rising clk when wr_en=1; reads are combinational.
- State registers: wr_ptr, rd_ptr (ADDR_W, wrap mod DEPTH), count (ADDR_W+1), pop_err.
- Reset (rst=0, async):
  - wr_ptr=rd_ptr=0, count=0, pop_err=0.
  - Outputs therefore: in_ready=1, out_valid=0, out_pair_valid=0, rf_wr_en=0.
- in_ready = (count != DEPTH), registered-count based. No write-through when full, even if a pop occurs the same cycle.
- push = in_valid & in_ready.
  - rf_wr_en=push, rf_wr_addr=wr_ptr, rf_wr_data=in_data, all combinational.
  - On the clock edge: wr_ptr+1.
- rf_rd0_addr=rd_ptr; rf_rd1_addr=rd_ptr+1 (mod DEPTH).
- out_data0=rf_rd0_data; out_data1=rf_rd1_data, both combinational.
- out_valid=(count>=1); out_pair_valid=(count>=2).
- Pop resolution (pair has priority):
  - If out_pair_ready & out_pair_valid: pop 2, rd_ptr+2.
  - Else if out_ready & out_valid: pop 1, rd_ptr+1.
  - Else pop 0.
- Illegal pop: out_pair_ready with count<2, or out_ready with count==0 (when not overridden by a legal pair pop). Sets pop_err; no state change for that request.
- count_next = count + push - pops. Simultaneous push and pop is legal whenever count<DEPTH.
- Latency: word pushed in cycle N is visible on out_data0 in cycle N+1 when the FIFO was empty. No bypass.
- flush=1 on a clock edge: wr_ptr=rd_ptr=count=0, pop_err=0. Flush overrides any push/pop in that cycle; rf_wr_en is still driven per push (the write is harmless, the pointer is reset).
- Reset mid-operation: all state clears immediately. reg_file contents are not touched.
- Pointer wrap: 3 -> 0 for both pointers; pair read at rd_ptr=3 uses rd1_addr=0.

Decomposition:
- Shared package: DATA_W=9, ADDR_W=2, DEPTH=4 constants, and a count type of ADDR_W+1 bits, reused by reg_file and the cipher core.
- No sub-module. Pointer logic is inline; the reg_file is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle: rst=0 for 1 cycle -> count=0, in_ready=1, out_valid=0, rf_wr_en=0, pop_err=0.
- Push 92, 65 on consecutive cycles -> rf_wr_addr 0 then 1; next cycle count=2, out_data0=92, out_data1=65, out_pair_valid=1.
- Fill 4 words (12, 34, 56, 78) -> count=4, in_ready=0. Then in_valid=1 with out_ready=1 -> no write (rf_wr_en=0), count=3, head=34.
- Wrap: push 5 words and pop 1 per cycle with rd_ptr at 3 -> rf_rd1_addr=0; pair pop returns entries 3 and 0 in order; count is correct after each step.
- Simultaneous push + pair pop at count=2 -> count=1 next cycle, head=new word. out_ready and out_pair_ready both high -> pair wins.
- Illegal pair pop at count=1 -> pop_err=1 and stays set; count unchanged. flush=1 -> count=0, pop_err=0. Async rst mid-push -> state clears without waiting for a clk edge.
